// File: rtl/hdmi_pkg.sv
// Shared definitions for the HDMI word-alignment controller:
// FSM state encoding, TMDS control-token constants and a token-match helper.
package hdmi_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_MEASURE,
        S_EVAL,
        S_SLIP,
        S_CENTER,
        S_LOCKED
    } state_t;

    localparam logic [9:0] TOK0 = 10'h354;
    localparam logic [9:0] TOK1 = 10'h0ab;
    localparam logic [9:0] TOK2 = 10'h154;
    localparam logic [9:0] TOK3 = 10'h2ab;

    localparam logic [4:0] TAP_LAST  = 5'd31;
    localparam logic [3:0] SLIP_LAST = 4'd9;

    function automatic logic is_token(input logic [9:0] w);
        return (w == TOK0) || (w == TOK1) || (w == TOK2) || (w == TOK3);
    endfunction

endpackage

// File: rtl/hdmi_align_ctrl_if.sv
// Bundle of the alignment controller's datapath/control signals.
// master: deserializer side (drives word/delay/restart); slave: controller.
interface hdmi_align_ctrl_if;
    logic       restart;
    logic [9:0] word;
    logic [4:0] delay_in;
    logic       ce;
    logic [4:0] delay_out;
    logic       bitslip;
    logic       locked;
    logic [5:0] eye;

    modport master (
        output restart, word, delay_in,
        input  ce, delay_out, bitslip, locked, eye
    );

    modport slave (
        input  restart, word, delay_in,
        output ce, delay_out, bitslip, locked, eye
    );
endinterface

// File: rtl/hdmi_token_det.sv
// Registered TMDS control-token detector.
// Ports: i_clk, i_reset, i_word (raw word) -> o_tok (high the cycle after a token).
module hdmi_token_det
    import hdmi_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [9:0] i_word,
    output logic       o_tok
);

    logic r_tok;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_tok <= 1'b0;
        else         r_tok <= is_token(i_word);
    end

    assign o_tok = r_tok;

endmodule

// File: rtl/hdmi_align_ctrl.sv
// HDMI word-alignment controller: sweeps IDELAY taps 0..31, finds the widest
// run of taps with enough control tokens, centers on it, else bit-slips.
// Ports: i_clk, i_reset, i_restart, i_word, i_delay -> o_ce, o_delay,
// o_bitslip, o_locked, o_eye.  Optional HDMI_ALIGN_MONITOR_EN adds a
// loss-of-token watchdog in LOCKED.
module hdmi_align_ctrl
    import hdmi_pkg::*;
#(
    parameter int SETTLE_CYCLES = 16,
    parameter int WINDOW_LG     = 10,
    parameter int TOKEN_MIN     = 8,
    parameter int MIN_EYE       = 4,
    parameter int LOSS_LG       = 20
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_restart,
    input  logic [9:0] i_word,
    input  logic [4:0] i_delay,
    output logic       o_ce,
    output logic [4:0] o_delay,
    output logic       o_bitslip,
    output logic       o_locked,
    output logic [5:0] o_eye
);

    localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_CYCLES - 1);
    localparam logic [31:0] WIN_LAST    = 32'((1 << WINDOW_LG) - 1);
    localparam logic [31:0] TOK_NEED    = 32'(TOKEN_MIN);
    localparam logic [5:0]  EYE_NEED    = 6'(MIN_EYE);

    state_t      r_state;
    logic [4:0]  r_tap;
    logic [31:0] r_cnt;
    logic [31:0] r_tokcnt;
    logic [4:0]  r_run_start;
    logic [5:0]  r_run_len;
    logic [4:0]  r_best_start;
    logic [5:0]  r_best_len;
    logic [3:0]  r_slips;
    logic        r_ce;
    logic [4:0]  r_delay;
    logic        r_bitslip;
    logic        r_locked;
    logic [5:0]  r_eye;
`ifdef HDMI_ALIGN_MONITOR_EN
    logic [LOSS_LG-1:0] r_loss;
`endif

    logic       w_tok;
    logic       w_good;
    logic [4:0] w_run_start_n;
    logic [5:0] w_run_len_n;
    logic [4:0] w_best_start_n;
    logic [5:0] w_best_len_n;
    logic [5:0] w_len_m1;
    logic [4:0] w_center;

    hdmi_token_det u_det (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_word  (i_word),
        .o_tok   (w_tok)
    );

    // Run/best bookkeeping for the tap under evaluation; best is updated
    // as a run grows, so a strictly longer later run replaces it while an
    // equal-length later run never does.
    always_comb begin
        w_good         = (r_tokcnt >= TOK_NEED) && (i_delay == r_tap);
        w_run_len_n    = 6'd0;
        w_run_start_n  = r_run_start;
        if (w_good) begin
            w_run_len_n   = r_run_len + 6'd1;
            w_run_start_n = (r_run_len == 6'd0) ? r_tap : r_run_start;
        end
        w_best_len_n   = r_best_len;
        w_best_start_n = r_best_start;
        if (w_run_len_n > r_best_len) begin
            w_best_len_n   = w_run_len_n;
            w_best_start_n = w_run_start_n;
        end
        w_len_m1 = w_best_len_n - 6'd1;
        w_center = w_best_start_n + w_len_m1[5:1];
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_tap        <= '0;
            r_cnt        <= '0;
            r_tokcnt     <= '0;
            r_run_start  <= '0;
            r_run_len    <= '0;
            r_best_start <= '0;
            r_best_len   <= '0;
            r_slips      <= '0;
            r_ce         <= 1'b0;
            r_delay      <= '0;
            r_bitslip    <= 1'b0;
            r_locked     <= 1'b0;
            r_eye        <= '0;
`ifdef HDMI_ALIGN_MONITOR_EN
            r_loss       <= '0;
`endif
        end else if (i_restart) begin
            r_state   <= S_IDLE;
            r_ce      <= 1'b0;
            r_bitslip <= 1'b0;
            r_locked  <= 1'b0;
        end else begin
            r_ce      <= 1'b0;
            r_bitslip <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    r_tap        <= '0;
                    r_run_start  <= '0;
                    r_run_len    <= '0;
                    r_best_start <= '0;
                    r_best_len   <= '0;
                    r_slips      <= '0;
                    r_ce         <= 1'b1;
                    r_delay      <= '0;
                    r_state      <= S_LOAD;
                end
                S_LOAD: begin
                    r_cnt   <= '0;
                    r_state <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (r_cnt == SETTLE_LAST) begin
                        r_cnt    <= '0;
                        r_tokcnt <= '0;
                        r_state  <= S_MEASURE;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                S_MEASURE: begin
                    if (w_tok && (r_tokcnt < TOK_NEED))
                        r_tokcnt <= r_tokcnt + 32'd1;
                    if (r_cnt == WIN_LAST) r_state <= S_EVAL;
                    else                   r_cnt   <= r_cnt + 32'd1;
                end
                S_EVAL: begin
                    r_run_len    <= w_run_len_n;
                    r_run_start  <= w_run_start_n;
                    r_best_len   <= w_best_len_n;
                    r_best_start <= w_best_start_n;
                    if (r_tap != TAP_LAST) begin
                        r_tap   <= r_tap + 5'd1;
                        r_delay <= r_tap + 5'd1;
                        r_ce    <= 1'b1;
                        r_state <= S_LOAD;
                    end else if (w_best_len_n >= EYE_NEED) begin
                        r_ce    <= 1'b1;
                        r_delay <= w_center;
                        r_eye   <= w_best_len_n;
                        r_state <= S_CENTER;
                    end else begin
                        r_bitslip    <= 1'b1;
                        r_slips      <= (r_slips == SLIP_LAST) ? 4'd0 : r_slips + 4'd1;
                        r_tap        <= '0;
                        r_run_start  <= '0;
                        r_run_len    <= '0;
                        r_best_start <= '0;
                        r_best_len   <= '0;
                        r_cnt        <= '0;
                        r_state      <= S_SLIP;
                    end
                end
                S_SLIP: begin
                    if (r_cnt == SETTLE_LAST) begin
                        r_ce    <= 1'b1;
                        r_delay <= '0;
                        r_state <= S_LOAD;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                S_CENTER: begin
                    r_locked <= 1'b1;
`ifdef HDMI_ALIGN_MONITOR_EN
                    r_loss   <= '0;
`endif
                    r_state  <= S_LOCKED;
                end
                S_LOCKED: begin
`ifdef HDMI_ALIGN_MONITOR_EN
                    if (w_tok) begin
                        r_loss <= '0;
                    end else if (r_loss == '1) begin
                        r_locked <= 1'b0;
                        r_state  <= S_IDLE;
                    end else begin
                        r_loss <= r_loss + 1'b1;
                    end
`else
                    r_state <= S_LOCKED;
`endif
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_ce      = r_ce;
    assign o_delay   = r_delay;
    assign o_bitslip = r_bitslip;
    assign o_locked  = r_locked;
    assign o_eye     = r_eye;

endmodule

// File: doc/hdmi_align_ctrl.md
HDMI_ALIGN_CTRL -- requirements
Module: hdmi_align_ctrl

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 16: cycles waited after each delay load before measuring.
REQ-002 SHALL have parameter WINDOW_LG, default 10: measurement window of 2^WINDOW_LG words.
REQ-003 SHALL have parameter TOKEN_MIN, default 8: minimum control-token count per window for a tap to be good.
REQ-004 SHALL have parameter MIN_EYE, default 4: minimum good-run length accepted as an eye.
REQ-005 SHALL have parameter LOSS_LG, default 20: loss-of-sync timeout of 2^LOSS_LG cycles.
REQ-006 Ports (clock and reset first):
- i_clk  in  1  single clock (pixel clock); all logic on its rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_restart  in  1  one-cycle request to restart alignment.
- i_word  in  10  raw deserialized TMDS word.
- i_delay  in  5  current tap value reported by the deserializer.
- o_ce  out  1  one-cycle load strobe to the deserializer delay element.
- o_delay  out  5  tap value to load on o_ce.
- o_bitslip  out  1  one-cycle word-boundary slip request.
- o_locked  out  1  alignment complete.
- o_eye  out  6  width of the selected eye, in taps.

Function
REQ-007 A word SHALL count as a control token iff it equals 10'h354, 10'h0ab, 10'h154 or 10'h2ab.
REQ-008 States SHALL be IDLE, LOAD, SETTLE, MEASURE, EVAL, SLIP, CENTER, LOCKED.
REQ-009 IDLE SHALL clear tap=0, run and best registers, and the slip count; next cycle -> LOAD.
REQ-010 LOAD SHALL assert o_ce for exactly one cycle with o_delay=tap; -> SETTLE.
REQ-011 SETTLE SHALL wait SETTLE_CYCLES cycles; -> MEASURE.
REQ-012 MEASURE SHALL count tokens over exactly 2^WINDOW_LG consecutive cycles, saturating the counter at TOKEN_MIN; -> EVAL.
REQ-013 EVAL SHALL mark the tap good iff count>=TOKEN_MIN and i_delay==tap.
REQ-014 On a good tap, EVAL SHALL extend the current run; on a bad tap, it SHALL end the run.
REQ-015 A run strictly longer than the best run SHALL replace it, recording start and length; ties SHALL keep the earlier run.
REQ-016 Taps SHALL be swept linearly 0..31 with no wrap-around; EVAL at tap 31 SHALL close any open run and then evaluate the result.
REQ-017 If best length>=MIN_EYE, the controller SHALL go to CENTER; otherwise it SHALL go to SLIP.
REQ-018 SLIP SHALL pulse o_bitslip for one cycle, increment the slip count, clear the sweep registers, and wait SETTLE_CYCLES cycles before entering LOAD at tap 0.
REQ-019 After 10 slips without an eye, the slip count SHALL wrap to 0 and sweeping SHALL continue indefinitely; o_locked SHALL stay 0 throughout.
REQ-020 CENTER SHALL load tap = start + ((length-1)>>1) using one o_ce pulse, set o_eye=length, and go to LOCKED.
REQ-021 LOCKED SHALL hold o_locked=1.
REQ-022 i_restart SHALL force IDLE from any state within one cycle and clear o_locked on the following edge; i_restart during IDLE SHALL be harmless.
REQ-023 o_ce and o_bitslip SHALL never be asserted in the same cycle, and each SHALL be exactly one cycle wide.

Reset
REQ-024 Asserting i_reset SHALL immediately force IDLE, o_ce=0, o_delay=0, o_bitslip=0, o_locked=0, o_eye=0, and clear all counters.
REQ-025 Reset mid-sweep or mid-slip SHALL discard all eye data; after deassertion, alignment SHALL restart from tap 0.

Configuration
REQ-026 Macro HDMI_ALIGN_MONITOR_EN: when defined, LOCKED SHALL count cycles since the last control token.
REQ-027 With HDMI_ALIGN_MONITOR_EN defined, reaching 2^LOSS_LG cycles without a token SHALL clear o_locked and go to IDLE.
REQ-028 Without HDMI_ALIGN_MONITOR_EN, LOCKED SHALL persist until i_restart or i_reset, and the monitor counter SHALL not exist.

Structure
REQ-029 The state encoding and the four TMDS control-token constants SHALL live in shared package hdmi_pkg.
REQ-030 Token detection SHALL be a sub-module hdmi_token_det: one registered output that is high the cycle after a token.
REQ-031 All remaining logic SHALL live in hdmi_align_ctrl.

Verification
REQ-032 Tokens good at taps 10..17 only -> exactly 32 o_ce sweep pulses, then center o_delay=13, o_eye=8, o_locked=1.
REQ-033 Good runs 3..6 and 20..23 (tie) -> o_delay=4, o_eye=4.
REQ-034 No tokens at any tap -> o_bitslip pulses once per sweep, every 32 loads, o_locked stays 0 across 12 sweeps.
REQ-035 i_reset asserted at tap 20 mid-MEASURE -> outputs zero asynchronously; after release, the first o_ce has o_delay=0.
REQ-036 With HDMI_ALIGN_MONITOR_EN defined and LOSS_LG=8: locked, then tokens stopped -> o_locked falls 2^8+1 cycles later and a new sweep starts at tap 0.
REQ-037 i_delay stuck at 0 while tokens are good everywhere -> only tap 0 is good, so no eye is found and o_bitslip pulses.
